aes_spi_slave: RTL and testbench

- SPI-side front end of the AES accelerator. It answers the host that shifts in {text[127:0], key[K-1:0], dir[7:0]} MSB-first while load is high.
- After load falls, it hands the captured frame to the AES core and waits for the core's result.
- It then raises done and shifts the 128-bit result out on sdo, MSB first.
- Everything runs in the single clk domain; sck, sdi and load are synchronized and edge-detected.

---
 rtl/aes_spi_slave_if.sv | 23 ++
 rtl/aes_spi_slave.sv | 145 ++++++++++++++
 tb/tb_aes_spi_slave.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_slave_if.sv
// Core-side handshake between the SPI front end and the AES core.
interface aes_spi_slave_if #(
  parameter int unsigned K = 128
) ();
  logic [127:0] core_text;
  logic [K-1:0] core_key;
  logic         core_dir;
  logic         core_start;
  logic         core_done;
  logic [127:0] core_result;

  // Front end issues the job and consumes the result.
  modport master (
    output core_text, core_key, core_dir, core_start,
    input  core_done, core_result
  );

  // AES core side.
  modport slave (
    input  core_text, core_key, core_dir, core_start,
    output core_done, core_result
  );
endinterface

// File: rtl/aes_spi_slave.sv
// SPI front end of the AES accelerator: captures {text, key, dir} from the
// host, starts the core, then serialises the 128-bit result on sdo.
module aes_spi_slave #(
  parameter int unsigned K    = 128,
  parameter int unsigned SYNC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sck,
  input  logic            sdi,
  input  logic            load,
  output logic            sdo,
  output logic            done,
  output logic            err,
  aes_spi_slave_if.master core
);

  localparam int unsigned TOTAL = K + 136;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned OW    = 7;

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, SHIFT} state_t;

  state_t            state;
  logic [SYNC-1:0]   sck_sy, sdi_sy, load_sy;
  logic              sck_d, load_d;
  logic [CW-1:0]     cnt;
  logic [TOTAL-1:0]  shreg;
  logic [127:0]      oreg;
  logic [OW-1:0]     ocnt;

  logic              sck_s, sdi_s, load_s;
  logic              sck_rise, sck_fall, load_rise, load_fall;
  logic [CW-1:0]     cnt_nxt;
  logic [TOTAL-1:0]  sh_nxt;

  // Synchronise host pins and keep a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sy  <= '0;
      sdi_sy  <= '0;
      load_sy <= '0;
      sck_d   <= 1'b0;
      load_d  <= 1'b0;
    end else begin
      sck_sy  <= {sck_sy[SYNC-2:0], sck};
      sdi_sy  <= {sdi_sy[SYNC-2:0], sdi};
      load_sy <= {load_sy[SYNC-2:0], load};
      sck_d   <= sck_sy[SYNC-1];
      load_d  <= load_sy[SYNC-1];
    end
  end

  assign sck_s     = sck_sy[SYNC-1];
  assign sdi_s     = sdi_sy[SYNC-1];
  assign load_s    = load_sy[SYNC-1];
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign load_rise = load_s & ~load_d;
  assign load_fall = ~load_s & load_d;

  // Next shift-register/counter values; a rise coinciding with load fall still counts.
  always_comb begin
    cnt_nxt = cnt;
    sh_nxt  = shreg;
    if (sck_rise) begin
      sh_nxt = (shreg << 1) | TOTAL'(sdi_s);
      if (cnt != CW'(TOTAL + 1)) begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Frame capture, core handshake and result shift-out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      shreg           <= '0;
      oreg            <= '0;
      ocnt            <= '0;
      sdo             <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      core.core_text  <= '0;
      core.core_key   <= '0;
      core.core_dir   <= 1'b0;
      core.core_start <= 1'b0;
    end else begin
      core.core_start <= 1'b0;
      if (load_rise) begin
        // New frame wins over whatever was in flight.
        state <= LOAD;
        cnt   <= '0;
        err   <= 1'b0;
        done  <= 1'b0;
        sdo   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            cnt   <= cnt_nxt;
            shreg <= sh_nxt;
            if (load_fall) begin
              if (cnt_nxt == CW'(TOTAL)) begin
                core.core_text  <= sh_nxt[TOTAL-1 -: 128];
                core.core_key   <= sh_nxt[K+7:8];
                core.core_dir   <= sh_nxt[0];
                core.core_start <= 1'b1;
                state           <= BUSY;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
          BUSY: begin
            if (core.core_done) begin
              oreg  <= core.core_result;
              sdo   <= core.core_result[127];
              done  <= 1'b1;
              ocnt  <= '0;
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (sck_fall) begin
              oreg <= oreg << 1;
              ocnt <= ocnt + OW'(1);
              if (ocnt == OW'(127)) begin
                done  <= 1'b0;
                sdo   <= 1'b0;
                state <= IDLE;
              end else begin
                sdo <= oreg[126];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_spi_slave.sv
// Directed bench for aes_spi_slave: K=128 and K=256 instances, behavioural core.
module tb_aes_spi_slave;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic load0 = 1'b0;
  logic load1 = 1'b0;
  logic sdo0, done0, err0, sdo1, done1, err1;

  int n_cmp = 0;
  int n_bad = 0;
  int lat0 = 20;
  int lat1 = 20;
  int cd0 = 0;
  int cd1 = 0;
  int starts0 = 0;
  int starts1 = 0;
  logic [127:0] res0 = '0;
  logic [127:0] res1 = '0;

  logic [127:0] t1   = 128'h3243F6A8885A308D313198A2E0370734;
  logic [127:0] key1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  logic [127:0] c1   = 128'h3925841D02DC09FBDC118597196A0B32;
  logic [127:0] t3   = 128'h00112233445566778899aabbccddeeff;
  logic [255:0] key3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic [127:0] r3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic [391:0] f1, f2, f3;
  logic [127:0] rd;

  always #5 clk = ~clk;

  aes_spi_slave_if #(.K(128)) bus0 ();
  aes_spi_slave_if #(.K(256)) bus1 ();

  aes_spi_slave #(.K(128), .SYNC(2)) dut0 (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load0),
    .sdo(sdo0), .done(done0), .err(err0), .core(bus0.master)
  );

  aes_spi_slave #(.K(256), .SYNC(2)) dut1 (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load1),
    .sdo(sdo1), .done(done1), .err(err1), .core(bus1.master)
  );

  // Behavioural cores: one-cycle done pulse lat cycles after start.
  assign bus0.core_done   = (cd0 == 1);
  assign bus0.core_result = res0;
  assign bus1.core_done   = (cd1 == 1);
  assign bus1.core_result = res1;

  always @(posedge clk) begin
    if (bus0.core_start) begin
      cd0     <= lat0;
      starts0 <= starts0 + 1;
    end else if (cd0 != 0) begin
      cd0 <= cd0 - 1;
    end
    if (bus1.core_start) begin
      cd1     <= lat1;
      starts1 <= starts1 + 1;
    end else if (cd1 != 0) begin
      cd1 <= cd1 - 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_sdo(input int w);
    return (w == 0) ? sdo0 : sdo1;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 0) ? done0 : done1;
  endfunction

  task automatic set_load(input int w, input logic v);
    if (w == 0) load0 = v;
    else load1 = v;
  endtask

  task automatic frame_begin(input int w);
    set_load(w, 1'b1);
    tick(8);
  endtask

  task automatic shift_bits(input logic [391:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      sck = 1'b0;
      tick(5);
      sck = 1'b1;
      tick(5);
    end
  endtask

  task automatic frame_end(input int w);
    sck = 1'b0;
    tick(5);
    set_load(w, 1'b0);
    tick(6);
  endtask

  task automatic wait_done(input int w, input string tag);
    int k;
    k = 0;
    while (get_done(w) !== 1'b1 && k < 500) begin
      tick(1);
      k++;
    end
    chk(tag, 256'(get_done(w)), 256'(1));
  endtask

  task automatic read_bits(input int w, input int n, output logic [127:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      sck = 1'b1;
      tick(5);
      r[127 - i] = get_sdo(w);
      sck = 1'b0;
      tick(5);
    end
  endtask

  initial begin
    f1 = {128'h0, t1, key1, 8'h00};
    f2 = {128'h0, c1, key1, 8'h01};
    f3 = {t3, key3, 8'h00};

    // Reset values
    tick(3);
    chk("rst_sdo", 256'(sdo0), 256'(0));
    chk("rst_done", 256'(done0), 256'(0));
    chk("rst_err", 256'(err0), 256'(0));
    chk("rst_start", 256'(bus0.core_start), 256'(0));
    chk("rst_text", 256'(bus0.core_text), 256'(0));
    chk("rst_key1", 256'(bus1.core_key), 256'(0));
    reset = 1'b1;
    tick(3);

    // Encrypt frame
    res0 = c1;
    frame_begin(0);
    shift_bits(f1, 264);
    frame_end(0);
    wait_done(0, "enc_done");
    chk("enc_starts", 256'(starts0), 256'(1));
    chk("enc_text", 256'(bus0.core_text), 256'(t1));
    chk("enc_key", 256'(bus0.core_key), 256'(key1));
    chk("enc_dir", 256'(bus0.core_dir), 256'(0));
    read_bits(0, 128, rd);
    chk("enc_read", 256'(rd), 256'(c1));
    tick(2);
    chk("enc_done_low", 256'(done0), 256'(0));
    chk("enc_sdo_low", 256'(sdo0), 256'(0));

    // Decrypt frame
    res0 = t1;
    frame_begin(0);
    shift_bits(f2, 264);
    frame_end(0);
    wait_done(0, "dec_done");
    chk("dec_dir", 256'(bus0.core_dir), 256'(1));
    chk("dec_text", 256'(bus0.core_text), 256'(c1));
    read_bits(0, 128, rd);
    chk("dec_read", 256'(rd), 256'(t1));
    chk("dec_starts", 256'(starts0), 256'(2));

    // Short frame (263 bits)
    frame_begin(0);
    shift_bits(f1 >> 1, 263);
    frame_end(0);
    tick(4);
    chk("short_err", 256'(err0), 256'(1));
    chk("short_starts", 256'(starts0), 256'(2));
    chk("short_done", 256'(done0), 256'(0));

    // Correct frame clears err and completes
    res0 = c1;
    frame_begin(0);
    chk("err_clr", 256'(err0), 256'(0));
    shift_bits(f1, 264);
    frame_end(0);
    wait_done(0, "rec_done");
    read_bits(0, 128, rd);
    chk("rec_read", 256'(rd), 256'(c1));
    chk("rec_starts", 256'(starts0), 256'(3));

    // Abort during BUSY: late core_done must be ignored
    lat0 = 100;
    frame_begin(0);
    shift_bits(f1, 264);
    frame_end(0);
    tick(10);
    chk("busy_nodone", 256'(done0), 256'(0));
    chk("busy_starts", 256'(starts0), 256'(4));
    frame_begin(0);
    tick(120);
    chk("late_ignored", 256'(done0), 256'(0));
    lat0 = 20;
    res0 = t1;
    shift_bits(f2, 264);
    frame_end(0);
    wait_done(0, "ab1_done");
    chk("ab1_dir", 256'(bus0.core_dir), 256'(1));

    // Abort mid shift-out after 40 bits
    read_bits(0, 40, rd);
    chk("ab2_part", 256'(rd[127:88]), 256'(t1[127:88]));
    frame_begin(0);
    chk("ab2_done", 256'(done0), 256'(0));
    chk("ab2_sdo", 256'(sdo0), 256'(0));
    res0 = c1;
    shift_bits(f1, 264);
    frame_end(0);
    wait_done(0, "ab2_done2");
    read_bits(0, 128, rd);
    chk("ab2_read", 256'(rd), 256'(c1));
    chk("ab2_starts", 256'(starts0), 256'(6));

    // Async reset after 60 result bits
    frame_begin(0);
    shift_bits(f1, 264);
    frame_end(0);
    wait_done(0, "rs_done");
    read_bits(0, 60, rd);
    chk("rs_part", 256'(rd[127:68]), 256'(c1[127:68]));
    reset = 1'b0;
    #1;
    chk("rs_sdo", 256'(sdo0), 256'(0));
    chk("rs_done0", 256'(done0), 256'(0));
    chk("rs_err", 256'(err0), 256'(0));
    chk("rs_text", 256'(bus0.core_text), 256'(0));
    tick(2);
    reset = 1'b1;
    tick(3);
    res0 = t1;
    frame_begin(0);
    shift_bits(f2, 264);
    frame_end(0);
    wait_done(0, "post_rs_done");
    read_bits(0, 128, rd);
    chk("post_rs_read", 256'(rd), 256'(t1));
    chk("post_rs_starts", 256'(starts0), 256'(8));

    // K=256 frame (392 bits)
    res1 = r3;
    frame_begin(1);
    shift_bits(f3, 392);
    frame_end(1);
    wait_done(1, "k256_done");
    chk("k256_key", 256'(bus1.core_key), key3);
    chk("k256_text", 256'(bus1.core_text), 256'(t3));
    chk("k256_err", 256'(err1), 256'(0));
    read_bits(1, 128, rd);
    chk("k256_read", 256'(rd), 256'(r3));
    chk("k256_starts", 256'(starts1), 256'(1));
    tick(2);
    chk("k256_done_low", 256'(done1), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
